// File: rtl/ccr_cond_eval_if.sv
// rtl/ccr_cond_eval_if.sv - ALU flag-update and branch-query bundle for ccr_cond_eval
interface ccr_cond_eval_if #(
  parameter int OP_SIZE = 4
);
  logic               upd_valid;
  logic [OP_SIZE-1:0] upd_r;
  logic [1:0]         upd_cv;
  logic [3:0]         upd_mask;
  logic               q_valid;
  logic [3:0]         q_cond;
  logic               q_ready;
  logic               q_done;
  logic               q_taken;

  modport master (
    output upd_valid, upd_r, upd_cv, upd_mask, q_valid, q_cond,
    input  q_ready, q_done, q_taken
  );

  modport slave (
    input  upd_valid, upd_r, upd_cv, upd_mask, q_valid, q_cond,
    output q_ready, q_done, q_taken
  );
endinterface

// File: rtl/ccr_cond_eval.sv
// rtl/ccr_cond_eval.sv - CVNZ condition code register with 3-cycle branch-condition query FSM
// Optional taken-branch counter enabled by macro CCR_STATS_EN.
module ccr_cond_eval #(
  parameter int OP_SIZE = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  ccr_cond_eval_if.slave   bus,
  output logic [3:0]       ccr
`ifdef CCR_STATS_EN
  ,
  output logic [CNT_W-1:0] taken_cnt
`endif
);

  if (OP_SIZE < 1 || CNT_W < 1) begin : g_bad_param
    $error("ccr_cond_eval: OP_SIZE and CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t     state_q;
  logic [3:0] cond_q;
  logic [3:0] ccr_q;
  logic [3:0] ccr_d;
  logic [3:0] upd_new;
  logic       done_q;
  logic       taken_q;
  logic       result;

  // Flag order {C,V,N,Z}; masked-off flags keep their old value.
  always_comb begin
    upd_new = {bus.upd_cv[1], bus.upd_cv[0], bus.upd_r[OP_SIZE-1], (bus.upd_r == '0)};
    ccr_d   = ccr_q;
    if (bus.upd_valid) begin
      ccr_d = (ccr_q & ~bus.upd_mask) | (upd_new & bus.upd_mask);
    end
  end

  always_comb begin
    logic c, v, n, z;
    c = ccr_q[3];
    v = ccr_q[2];
    n = ccr_q[1];
    z = ccr_q[0];
    result = 1'b0;
    case (cond_q)
      4'h0: result = 1'b1;
      4'h1: result = 1'b0;
      4'h2: result = ~(c | z);
      4'h3: result = c | z;
      4'h4: result = ~c;
      4'h5: result = c;
      4'h6: result = ~z;
      4'h7: result = z;
      4'h8: result = ~v;
      4'h9: result = v;
      4'hA: result = ~n;
      4'hB: result = n;
      4'hC: result = ~(n ^ v);
      4'hD: result = n ^ v;
      4'hE: result = ~(z | (n ^ v));
      4'hF: result = z | (n ^ v);
      default: result = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cond_q  <= 4'h0;
      ccr_q   <= 4'h0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      ccr_q  <= ccr_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.q_valid) begin
            cond_q  <= bus.q_cond;
            state_q <= EVAL;
          end
        end
        // Uses ccr_q as held this cycle, so an update landing on this edge is not seen.
        EVAL: begin
          taken_q <= result;
          done_q  <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef CCR_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == RESP && taken_q) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign taken_cnt = cnt_q;
`endif

  assign bus.q_ready = (state_q == IDLE) && !rst;
  assign bus.q_done  = done_q;
  assign bus.q_taken = taken_q;
  assign ccr         = ccr_q;

endmodule

// File: tb/tb_ccr_cond_eval.sv
// tb/tb_ccr_cond_eval.sv - directed self-checking bench for ccr_cond_eval
module tb_ccr_cond_eval;

  logic       clk;
  logic       rst;
  logic [3:0] ccr;
`ifdef CCR_STATS_EN
  logic [1:0] taken_cnt;
`endif

  int passed;
  int total;

  ccr_cond_eval_if #(.OP_SIZE(4)) bus ();

  ccr_cond_eval #(.OP_SIZE(4), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .ccr (ccr)
`ifdef CCR_STATS_EN
    ,
    .taken_cnt (taken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic upd(input logic [3:0] r, input logic [1:0] cv, input logic [3:0] mask);
    bus.upd_valid = 1'b1;
    bus.upd_r     = r;
    bus.upd_cv    = cv;
    bus.upd_mask  = mask;
    tick();
    bus.upd_valid = 1'b0;
  endtask

  task automatic query(input logic [3:0] cond, input logic exp_taken, input string tag);
    bus.q_valid = 1'b1;
    bus.q_cond  = cond;
    tick();
    bus.q_valid = 1'b0;
    tick();
    chk({tag, "_done"}, {7'd0, bus.q_done}, 8'd1);
    chk({tag, "_taken"}, {7'd0, bus.q_taken}, {7'd0, exp_taken});
    tick();
  endtask

  initial begin
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    passed = 0;
    total  = 0;
    rst = 1'b1;
    bus.upd_valid = 1'b0;
    bus.upd_r     = 4'h0;
    bus.upd_cv    = 2'b00;
    bus.upd_mask  = 4'h0;
    bus.q_valid   = 1'b0;
    bus.q_cond    = 4'h0;
    tick();
    tick();
    chk("rst_ready", {7'd0, bus.q_ready}, 8'd0);
    chk("rst_ccr", {4'd0, ccr}, 8'h00);
    chk("rst_done", {7'd0, bus.q_done}, 8'd0);
    chk("rst_taken", {7'd0, bus.q_taken}, 8'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", {7'd0, bus.q_ready}, 8'd1);

    // AND of zero result, C/V masked off
    upd(4'b0000, 2'b11, 4'b0011);
    chk("and_zero_ccr", {4'd0, ccr}, 8'h01);
    bus.q_valid = 1'b1;
    bus.q_cond  = 4'h7;
    tick();
    bus.q_valid = 1'b0;
    chk("beq_busy", {7'd0, bus.q_ready}, 8'd0);
    chk("beq_nodone", {7'd0, bus.q_done}, 8'd0);
    tick();
    chk("beq_done", {7'd0, bus.q_done}, 8'd1);
    chk("beq_taken", {7'd0, bus.q_taken}, 8'd1);
    tick();
    chk("beq_done_clr", {7'd0, bus.q_done}, 8'd0);
    chk("beq_idle", {7'd0, bus.q_ready}, 8'd1);

    upd(4'b0001, 2'b11, 4'b1111);
    chk("set_1100", {4'd0, ccr}, 8'h0C);
    upd(4'b1000, 2'b00, 4'b0011);
    chk("and_keep_cv", {4'd0, ccr}, 8'h0E);
    query(4'hB, 1'b1, "bmi");
    query(4'hA, 1'b0, "bpl");

    // Update and query accepted on the same edge
    bus.upd_valid = 1'b1;
    bus.upd_r     = 4'b0101;
    bus.upd_cv    = 2'b01;
    bus.upd_mask  = 4'b1111;
    bus.q_valid   = 1'b1;
    bus.q_cond    = 4'hD;
    tick();
    bus.upd_valid = 1'b0;
    bus.q_valid   = 1'b0;
    chk("same_ccr", {4'd0, ccr}, 8'h04);
    tick();
    chk("same_done", {7'd0, bus.q_done}, 8'd1);
    chk("same_taken", {7'd0, bus.q_taken}, 8'd1);
    tick();

    // Update landing on the EVAL edge is not seen by the query in flight
    upd(4'b0001, 2'b00, 4'b1111);
    chk("clr_ccr", {4'd0, ccr}, 8'h00);
    bus.q_valid = 1'b1;
    bus.q_cond  = 4'h2;
    tick();
    bus.q_valid   = 1'b0;
    bus.upd_valid = 1'b1;
    bus.upd_r     = 4'b0001;
    bus.upd_cv    = 2'b10;
    bus.upd_mask  = 4'b1000;
    tick();
    bus.upd_valid = 1'b0;
    chk("late_done", {7'd0, bus.q_done}, 8'd1);
    chk("late_taken", {7'd0, bus.q_taken}, 8'd1);
    chk("late_ccr", {4'd0, ccr}, 8'h08);
    tick();
    query(4'h2, 1'b0, "bhi_after");

    // Full condition table for two flag patterns
    exp_a = 16'hA969;
    exp_b = 16'hA699;
    upd(4'b1000, 2'b10, 4'b1111);
    chk("ccr_1010", {4'd0, ccr}, 8'h0A);
    for (int i = 0; i < 16; i++) begin
      query(4'(i), exp_a[i], $sformatf("tblA_%0h", i));
    end
    upd(4'b0000, 2'b01, 4'b1111);
    chk("ccr_0101", {4'd0, ccr}, 8'h05);
    for (int i = 0; i < 16; i++) begin
      query(4'(i), exp_b[i], $sformatf("tblB_%0h", i));
    end

    // Reset during EVAL aborts the query
    bus.q_valid = 1'b1;
    bus.q_cond  = 4'h0;
    tick();
    bus.q_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("abort_done", {7'd0, bus.q_done}, 8'd0);
    chk("abort_ccr", {4'd0, ccr}, 8'h00);
    chk("abort_ready_rst", {7'd0, bus.q_ready}, 8'd0);
    rst = 1'b0;
    tick();
    chk("abort_ready", {7'd0, bus.q_ready}, 8'd1);
    chk("abort_nodone", {7'd0, bus.q_done}, 8'd0);

    // q_valid held through RESP is only taken again from IDLE
    bus.q_valid = 1'b1;
    bus.q_cond  = 4'h4;
    tick();
    tick();
    chk("hold_done", {7'd0, bus.q_done}, 8'd1);
    chk("hold_taken", {7'd0, bus.q_taken}, 8'd1);
    chk("hold_resp_busy", {7'd0, bus.q_ready}, 8'd0);
    tick();
    chk("hold_idle", {7'd0, bus.q_ready}, 8'd1);
    chk("hold_idle_nodone", {7'd0, bus.q_done}, 8'd0);
    tick();
    chk("hold_reaccept", {7'd0, bus.q_ready}, 8'd0);
    bus.q_valid = 1'b0;
    tick();
    chk("hold_done2", {7'd0, bus.q_done}, 8'd1);
    tick();

`ifdef CCR_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("cnt_rst", {6'd0, taken_cnt}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      query(4'h0, 1'b1, $sformatf("cnt_bra%0d", i));
      chk($sformatf("cnt_val%0d", i), {6'd0, taken_cnt}, 8'((i + 1) % 4));
    end
    for (int i = 0; i < 3; i++) begin
      query(4'h1, 1'b0, $sformatf("cnt_brn%0d", i));
      chk($sformatf("cnt_hold%0d", i), {6'd0, taken_cnt}, 8'd1);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
